fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter IMEM_BYTES, default 4096, meaning the instruction memory size in bytes (1024 words).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port imem_addr, output, 32, the byte address to instruction memory port A.
REQ-006 The block SHALL have port imem_rd, input, 32, the instruction word from instruction memory port RD (combinational read of imem_addr).
REQ-007 The block SHALL have port redirect, input, 1, the branch/jump taken request from a later stage.
REQ-008 The block SHALL have port redirect_pc, input, 32, the branch/jump target byte address.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the IF/ID register holds a valid instruction.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the decode stage accepts the IF/ID contents this cycle.
REQ-011 The block SHALL have port out_instr, output, 32, the fetched instruction word.
REQ-012 The block SHALL have port out_pc, output, 32, the address of out_instr.
REQ-013 The block SHALL have port out_pc_plus4, output, 32, equal to out_pc + 4.
REQ-014 The block SHALL have port fetch_fault, output, 1, a sticky flag for a misaligned redirect or an out-of-range PC.
REQ-015 The block SHALL have port retired_count, output, 32, the number of instructions handed to decode.

Function
REQ-016 imem_addr SHALL equal the PC register combinationally, with no added latency.
REQ-017 The block SHALL assert load = (!out_valid || out_ready) in a cycle where reset=0 and redirect=0.
REQ-018 On load, {out_instr, out_pc, out_pc_plus4} SHALL capture {imem_rd, PC, PC+4}, out_valid SHALL become 1, and PC SHALL become PC+4 (modulo 2^32).
REQ-019 When out_valid=1 and out_ready=0 (stall), PC and the IF/ID contents SHALL hold, and out_instr SHALL stay stable until accepted.
REQ-020 A handoff SHALL occur when out_valid && out_ready on a clock edge; retired_count SHALL increment by 1 per handoff, wrapping from 2^32-1 to 0.
REQ-021 Redirect SHALL take priority over load and stall: PC SHALL become {redirect_pc[31:2], 2'b00} and out_valid SHALL become 0 (flush); no capture SHALL occur that cycle.
REQ-022 A handoff in the same cycle as a redirect SHALL still count in retired_count.
REQ-023 If redirect_pc[1:0] != 0 at a redirect, fetch_fault SHALL set.
REQ-024 If PC >= IMEM_BYTES at a load, fetch_fault SHALL set; the capture SHALL still occur, with out_instr = 32'h00000013 (NOP) instead of imem_rd.
REQ-025 fetch_fault SHALL clear only on reset.
REQ-026 Fetch latency SHALL be one cycle: an instruction at PC appears on out_instr on the edge after PC is presented, given no stall or redirect.
REQ-027 The state machine SHALL have three states: EMPTY (out_valid=0), FULL (out_valid=1, accepted or refilled), and STALLED (out_valid=1 and out_ready=0). Transitions: EMPTY->FULL on load; FULL->FULL on handoff plus load; FULL->STALLED on out_ready=0; any state->EMPTY on redirect or reset.

Reset
REQ-028 While reset=1 at a clock edge, PC SHALL become RESET_PC, out_valid 0, out_instr 0, out_pc 0, out_pc_plus4 0, fetch_fault 0, and retired_count 0.
REQ-029 Reset SHALL override redirect and load, and no handoff SHALL be counted on a reset edge.
REQ-030 Reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-031 Sequential fetch: mem words 0x0062E233, 0x00520533, 0x00A02023, with reset released and out_ready=1 -> out_instr follows that order one per cycle, out_pc = 0, 4, 8, and retired_count = 3 after three handoffs.
REQ-032 Stall: out_ready=0 for 3 cycles while out_instr=0x00520533 -> out_instr, out_pc=4, and imem_addr=8 all hold; the count does not change; the word is accepted on the first cycle out_ready=1.
REQ-033 Redirect: redirect=1 with redirect_pc=0x10 while out_valid=1 -> next cycle out_valid=0 and imem_addr=0x10; the following cycle out_pc=0x10 and out_instr=mem[4].
REQ-034 Redirect during stall plus misaligned target: out_ready=0 and redirect_pc=0x0E -> flush, PC=0x0C, fetch_fault=1 and stays 1 until reset.
REQ-035 Boundary: with IMEM_BYTES=16, sequential fetch reaches PC=0x10 -> out_instr=0x00000013 and fetch_fault=1; a separate case forcing retired_count=0xFFFFFFFF plus one handoff -> 0.
REQ-036 Reset mid-operation: reset=1 for one cycle after 2 handoffs -> PC=RESET_PC, out_valid=0, retired_count=0, and fetch restarts at mem[0].

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC to instruction memory and holds the fetched word in the IF/ID register.
// One-cycle fetch latency; the IF/ID register holds while decode stalls; redirect flushes it and retargets the PC.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h00000000,
   parameter int unsigned IMEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rd,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   output logic        fetch_fault,
   output logic [31:0] retired_count
);

   localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
   localparam logic [31:0] NOP_INSTR  = 32'h00000013;

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_FULL    = 2'd1,
      S_STALLED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] opc_q, opc_d;
   logic [31:0] opc4_q, opc4_d;
   logic        fault_q, fault_d;
   logic [31:0] count_q, count_d;
   logic        handoff;
   logic        load;
   logic        pc_out_of_range;

   assign out_valid       = (state_q != S_EMPTY);
   assign imem_addr       = pc_q;
   assign out_instr       = instr_q;
   assign out_pc          = opc_q;
   assign out_pc_plus4    = opc4_q;
   assign fetch_fault     = fault_q;
   assign retired_count   = count_q;
   assign pc_out_of_range = (pc_q >= IMEM_LIMIT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      opc4_d  = opc4_q;
      fault_d = fault_q;
      handoff = out_valid && out_ready;
      load    = !out_valid || out_ready;
      // A handoff still retires even when a redirect flushes the slot behind it.
      count_d = count_q + {31'b0, handoff};

      if (redirect) begin
         state_d = S_EMPTY;
         pc_d    = {redirect_pc[31:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
         end
      end else if (load) begin
         state_d = S_FULL;
         instr_d = pc_out_of_range ? NOP_INSTR : imem_rd;
         opc_d   = pc_q;
         opc4_d  = pc_q + 32'd4;
         pc_d    = pc_q + 32'd4;
         if (pc_out_of_range) begin
            fault_d = 1'b1;
         end
      end else begin
         state_d = S_STALLED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_EMPTY;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         opc_q   <= 32'h0;
         opc4_q  <= 32'h0;
         fault_q <= 1'b0;
         count_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         opc4_q  <= opc4_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, misaligned redirect, wrap, reset, and a small-memory boundary instance.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rd;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        fetch_fault;
   logic [31:0] retired_count;

   logic        s_reset;
   logic [31:0] s_imem_addr;
   logic [31:0] s_imem_rd;
   logic        s_redirect = 1'b0;
   logic [31:0] s_redirect_pc = 32'h0;
   logic        s_out_ready = 1'b1;
   logic        s_out_valid;
   logic [31:0] s_out_instr;
   logic [31:0] s_out_pc;
   logic [31:0] s_out_pc_plus4;
   logic        s_fetch_fault;
   logic [31:0] s_retired_count;

   logic [31:0] mem [0:63];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   assign imem_rd   = mem[imem_addr[7:2]];
   assign s_imem_rd = mem[s_imem_addr[7:2]];

   fetch_unit dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_pc_plus4(out_pc_plus4), .fetch_fault(fetch_fault), .retired_count(retired_count)
   );

   fetch_unit #(.IMEM_BYTES(16)) dut_small (
      .clk(clk), .reset(s_reset), .imem_addr(s_imem_addr), .imem_rd(s_imem_rd),
      .redirect(s_redirect), .redirect_pc(s_redirect_pc), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
      .out_pc_plus4(s_out_pc_plus4), .fetch_fault(s_fetch_fault), .retired_count(s_retired_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
      mem[0] = 32'h0062E233;
      mem[1] = 32'h00520533;
      mem[2] = 32'h00A02023;

      reset = 1'b1; s_reset = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
      step(); step();
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_pc4", out_pc_plus4, 32'h0);
      chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
      chk("rst_count", retired_count, 32'h0);

      // Sequential fetch
      reset = 1'b0;
      step();
      chk("seq0_instr", out_instr, 32'h0062E233);
      chk("seq0_pc", out_pc, 32'h0);
      chk("seq0_pc4", out_pc_plus4, 32'h4);
      chk("seq0_valid", {31'b0, out_valid}, 32'h1);
      chk("seq0_addr", imem_addr, 32'h4);
      step();
      chk("seq1_instr", out_instr, 32'h00520533);
      chk("seq1_pc", out_pc, 32'h4);
      chk("seq1_count", retired_count, 32'h1);

      // Stall for three cycles
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_instr", out_instr, 32'h00520533);
         chk("stall_pc", out_pc, 32'h4);
         chk("stall_addr", imem_addr, 32'h8);
         chk("stall_count", retired_count, 32'h1);
      end
      out_ready = 1'b1;
      step();
      chk("seq2_instr", out_instr, 32'h00A02023);
      chk("seq2_pc", out_pc, 32'h8);
      chk("seq2_count", retired_count, 32'h2);
      step();
      chk("seq3_count", retired_count, 32'h3);
      chk("seq3_pc", out_pc, 32'hC);

      // Redirect while valid, with a same-cycle handoff
      redirect = 1'b1; redirect_pc = 32'h10;
      step();
      redirect = 1'b0;
      chk("redir_valid", {31'b0, out_valid}, 32'h0);
      chk("redir_addr", imem_addr, 32'h10);
      chk("redir_count", retired_count, 32'h4);
      chk("redir_fault", {31'b0, fetch_fault}, 32'h0);
      step();
      chk("redir_pc", out_pc, 32'h10);
      chk("redir_instr", out_instr, mem[4]);
      chk("redir_count2", retired_count, 32'h4);

      // Misaligned redirect during stall
      out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0E;
      step();
      redirect = 1'b0; out_ready = 1'b1;
      chk("mis_valid", {31'b0, out_valid}, 32'h0);
      chk("mis_addr", imem_addr, 32'hC);
      chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
      chk("mis_count", retired_count, 32'h4);
      step();
      chk("mis_pc", out_pc, 32'hC);
      chk("mis_instr", out_instr, mem[3]);
      step(); step();
      chk("mis_sticky", {31'b0, fetch_fault}, 32'h1);

      // Retired count wraps
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      step();
      chk("wrap_count", retired_count, 32'h0);

      // Reset mid-stall after two handoffs
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst2_fault", {31'b0, fetch_fault}, 32'h0);
      step(); step(); step();
      chk("pre_rst_count", retired_count, 32'h2);
      out_ready = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; out_ready = 1'b1;
      chk("rst3_valid", {31'b0, out_valid}, 32'h0);
      chk("rst3_count", retired_count, 32'h0);
      chk("rst3_addr", imem_addr, 32'h0);
      chk("rst3_instr", out_instr, 32'h0);
      step();
      chk("restart_instr", out_instr, 32'h0062E233);
      chk("restart_pc", out_pc, 32'h0);

      // Small-memory boundary instance
      s_reset = 1'b1; step(); s_reset = 1'b0;
      step(); step(); step(); step();
      chk("bnd_last_pc", s_out_pc, 32'hC);
      chk("bnd_last_fault", {31'b0, s_fetch_fault}, 32'h0);
      step();
      chk("bnd_pc", s_out_pc, 32'h10);
      chk("bnd_instr", s_out_instr, 32'h00000013);
      chk("bnd_fault", {31'b0, s_fetch_fault}, 32'h1);
      chk("bnd_valid", {31'b0, s_out_valid}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
